// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle of the UART receiver.
// The receiver (master) drives the byte, its valid flag, the status pulses
// and the busy flag; the consumer (slave) drives the ready flag.
interface uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;
    logic       i_ready;

    modport master (
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_overrun,
        output o_busy,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_overrun,
        input  o_busy,
        output i_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver (LSB first, idle high).
// The serial line is brought into the clock domain by a two-flop synchroniser.
// A bit timer centres every sample on its bit: the start bit is confirmed at its
// midpoint, and each later bit is sampled one full bit period after the previous
// sample. Completed bytes go into a single-entry holding register with a
// valid/ready handshake. A low stop bit raises a frame error and parks the
// receiver until the line returns high, so a long break never looks like a
// stream of start bits.
module uart_rx #(
    parameter  int CLKS_PER_BIT = 87,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_rx,
    uart_rx_if.master    bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Timer value at a full bit period and at the middle of the start bit.
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

    // Synchroniser
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_s;

    // Frame FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_s;

    // Registered outputs
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    assign rx_s = rx_sync_q;

    // Next state of the two synchroniser stages.
    always_comb begin
        rx_meta_d = i_rx;
        rx_sync_d = rx_meta_q;
    end

    // Frame FSM: start-bit qualification, data sampling, stop-bit check.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_s = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d   = {CNT_W{1'b0}};
                bit_idx_d = 3'd0;
                if (rx_s == 1'b0) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (timer_q == MID_LAST) begin
                    timer_d = {CNT_W{1'b0}};
                    if (rx_s == 1'b0) begin
                        state_d = ST_DATA;
                    end else begin
                        // Line went back high before mid-bit: a glitch, not a start.
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (timer_q == BIT_LAST) begin
                    shift_d[bit_idx_q] = rx_s;
                    timer_d            = {CNT_W{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = {CNT_W{1'b0}};
                    if (rx_s == 1'b1) begin
                        // Back to IDLE at mid-stop so an immediate next start is seen.
                        byte_done_s = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_BREAK: begin
                timer_d = {CNT_W{1'b0}};
                if (rx_s == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                timer_d   = {CNT_W{1'b0}};
                bit_idx_d = 3'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Single-entry holding register with valid/ready handshake and overrun detection.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (byte_done_s) begin
            if (!valid_q) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (bus.i_ready) begin
                // Old byte leaves on this edge, so the new one can take its place.
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers; reset aborts any frame in progress silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= {CNT_W{1'b0}};
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=8.
// Stimulus is driven 1 time unit after each rising edge; outputs are observed
// on falling edges by a monitor that logs accepted bytes and pulse counts.
module tb_uart_rx;

    localparam int CPB = 8;

    logic clk;
    logic reset;
    logic i_rx;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .i_rx  (i_rx),
        .bus   (bus)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state.
    logic [7:0] acc_q[$];
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         hold_viol = 0;
    int         rise_cyc  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Falling-edge monitor: handshakes, pulses, and hold-until-accepted rule.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.o_valid && bus.i_ready) acc_q.push_back(bus.o_data);
            if (bus.o_frame_err) ferr_cnt <= ferr_cnt + 1;
            if (bus.o_overrun) ovr_cnt <= ovr_cnt + 1;
            if (bus.o_valid && !prev_valid) rise_cyc <= cyc;
            if (prev_valid && !prev_acc && (!bus.o_valid || bus.o_data != prev_data))
                hold_viol <= hold_viol + 1;
            prev_valid <= bus.o_valid;
            prev_acc   <= bus.o_valid && bus.i_ready;
            prev_data  <= bus.o_data;
        end else begin
            prev_valid <= 1'b0;
            prev_acc   <= 1'b0;
        end
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    logic rnd_en = 1'b0;

    // Advance n clocks; in random mode the consumer ready is re-rolled each cycle.
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_en) bus.i_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // One 8N1 frame; a bad stop keeps the line low for low_len clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int low_len);
        i_rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            hold(CPB);
        end
        if (stop_ok) begin
            i_rx = 1'b1;
            hold(CPB);
        end else begin
            i_rx = 1'b0;
            hold(low_len);
            i_rx = 1'b1;
        end
    endtask

    // Bounded wait for the accepted-byte log to reach target entries.
    task automatic wait_acc(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (acc_q.size() < target && n < budget) begin
            hold(1);
            n++;
        end
        check(name, acc_q.size(), target);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         low_len;
        int         exp_cnt;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base, f0, o0, exp_ferr, busy_cnt, t0;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, low_len: 0,  exp_cnt: 1, exp_data: 8'hA5, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop_ok: 1'b0, low_len: 30, exp_cnt: 0, exp_data: 8'h00, exp_ferr: 1};
        vecs[2] = '{data: 8'h3C, stop_ok: 1'b1, low_len: 0,  exp_cnt: 1, exp_data: 8'h3C, exp_ferr: 0};
        vecs[3] = '{data: 8'h00, stop_ok: 1'b1, low_len: 0,  exp_cnt: 1, exp_data: 8'h00, exp_ferr: 0};
        vecs[4] = '{data: 8'hFF, stop_ok: 1'b1, low_len: 0,  exp_cnt: 1, exp_data: 8'hFF, exp_ferr: 0};
        vecs[5] = '{data: 8'h81, stop_ok: 1'b1, low_len: 0,  exp_cnt: 1, exp_data: 8'h81, exp_ferr: 0};

        reset       = 1'b0;
        i_rx        = 1'b1;
        bus.i_ready = 1'b1;
        hold(3);

        // Reset state.
        @(negedge clk);
        check("rst_data", bus.o_data, 8'h00);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_ferr", bus.o_frame_err, 1'b0);
        check("rst_ovr", bus.o_overrun, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        hold(1);
        reset = 1'b1;
        hold(5);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            base = acc_q.size();
            f0   = ferr_cnt;
            o0   = ovr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].low_len);
            hold(12);
            wait_acc($sformatf("vec%0d_count", v), base + vecs[v].exp_cnt, 40);
            if (vecs[v].exp_cnt == 1 && acc_q.size() > base)
                check($sformatf("vec%0d_data", v), acc_q[base], vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
            check($sformatf("vec%0d_idle", v), bus.o_busy, 1'b0);
        end

        // Latency from line fall to o_valid: 2 sync + 9.5 bits + 1 register.
        t0 = cyc;
        send_frame(8'hC3, 1'b1, 0);
        hold(12);
        check_range("latency", rise_cyc - t0, 78, 80);

        // Back-to-back frames with no idle time.
        base = acc_q.size();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        hold(12);
        wait_acc("b2b_count", base + 2, 40);
        if (acc_q.size() >= base + 2) begin
            check("b2b_first", acc_q[base], 8'h00);
            check("b2b_second", acc_q[base + 1], 8'hFF);
        end

        // Short start glitch must be rejected.
        base = acc_q.size();
        f0   = ferr_cnt;
        i_rx = 1'b0;
        hold(2);
        i_rx = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.o_busy) busy_cnt++;
            hold(1);
        end
        check_range("glitch_busy", busy_cnt, 1, 7);
        check("glitch_acc", acc_q.size(), base);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_valid", bus.o_valid, 1'b0);

        // Overrun: holding register full while consumer is stalled.
        base = acc_q.size();
        o0   = ovr_cnt;
        bus.i_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        hold(4);
        send_frame(8'h22, 1'b1, 0);
        hold(10);
        @(negedge clk);
        check("ovr_valid", bus.o_valid, 1'b1);
        check("ovr_data", bus.o_data, 8'h11);
        check("ovr_pulses", ovr_cnt - o0, 1);
        hold(1);
        bus.i_ready = 1'b1;
        hold(1);
        @(negedge clk);
        check("ovr_drop", bus.o_valid, 1'b0);
        hold(20);
        check("ovr_acc_count", acc_q.size(), base + 1);
        if (acc_q.size() > base) check("ovr_acc_data", acc_q[base], 8'h11);

        // Reset in the middle of data bit 4, then a clean resend.
        base = acc_q.size();
        f0   = ferr_cnt;
        o0   = ovr_cnt;
        b    = 8'h5A;
        i_rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            i_rx = b[i];
            hold(CPB);
        end
        i_rx = b[4];
        hold(4);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_valid", bus.o_valid, 1'b0);
        hold(1);
        i_rx = 1'b1;
        hold(3);
        reset = 1'b1;
        @(negedge clk);
        check("rel_ferr", bus.o_frame_err, 1'b0);
        check("rel_ovr", bus.o_overrun, 1'b0);
        hold(10);
        send_frame(8'h5A, 1'b1, 0);
        hold(12);
        wait_acc("midrst_count", base + 1, 40);
        if (acc_q.size() > base) check("midrst_data", acc_q[base], 8'h5A);
        check("midrst_ferr", ferr_cnt - f0, 0);
        check("midrst_ovr", ovr_cnt - o0, 0);

        // Random frames against the reference: good frames arrive in order,
        // bad-stop frames only count a frame error.
        base     = acc_q.size();
        f0       = ferr_cnt;
        o0       = ovr_cnt;
        exp_ferr = 0;
        rnd_en   = 1'b1;
        for (int k = 0; k < 30; k++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                send_frame(b, 1'b0, $urandom_range(8, 30));
                exp_ferr++;
                hold($urandom_range(1, 20));
            end else begin
                send_frame(b, 1'b1, 0);
                exp_q.push_back(b);
                hold($urandom_range(0, 20));
            end
        end
        hold(20);
        rnd_en = 1'b0;
        bus.i_ready = 1'b1;
        wait_acc("rnd_count", base + exp_q.size(), 200);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < acc_q.size())
                check($sformatf("rnd_byte%0d", i), acc_q[base + i], exp_q[i]);
        end
        check("rnd_ferr", ferr_cnt - f0, exp_ferr);
        check("rnd_ovr", ovr_cnt - o0, 0);
        check("data_hold", hold_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
